// File: rtl/multicycle_adder_ctrl_if.sv
// Request/result bundle for the multicycle byte-serial adder.
//
// Handshake: a request is taken on a rising clock edge where start=1 and the
// sequencer is not busy (busy=0). ctrl_sub and both operands are sampled on
// that edge only. A request raised while busy=1 is dropped, not queued.
// data_resultRDY is a one-cycle pulse. It marks the edge on which
// data_result/carry_out/overflow take their new values, and these hold until
// the next completion. There is no back-pressure on the result side.
interface multicycle_adder_ctrl_if;
    logic        start;
    logic        ctrl_sub;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        carry_out;
    logic        overflow;
    logic        data_resultRDY;
    logic        busy;

    // Requester side: drives the operation, observes the result.
    modport master (
        output start, ctrl_sub, data_operandA, data_operandB,
        input  data_result, carry_out, overflow, data_resultRDY, busy
    );

    // Sequencer side.
    modport slave (
        input  start, ctrl_sub, data_operandA, data_operandB,
        output data_result, carry_out, overflow, data_resultRDY, busy
    );
endinterface

// File: rtl/multicycle_adder_ctrl.sv
// 32-bit add/subtract built from one 8-bit carry-lookahead slice stepped over
// four byte beats. The carry is registered between beats. Subtraction is done
// as A + ~B + 1, with the +1 entering as the initial carry.
module multicycle_adder_ctrl (
    input  logic                          clock,
    input  logic                          reset,
    multicycle_adder_ctrl_if.slave        bus,
    output logic [1:0]                    dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  beat_q, beat_d;
    logic        c_q, c_d;
    logic [31:0] opa_q, opa_d;
    logic [31:0] opb_q, opb_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] result_q, result_d;
    logic        cout_q, cout_d;
    logic        ovf_q, ovf_d;
    logic        rdy_q, rdy_d;

    // Slice datapath signals
    logic [7:0]  sl_a, sl_b, sl_g, sl_p, sl_sum;
    logic [8:0]  sl_c;
    logic        la_term;
    logic        la_carry;

    // 8-bit carry-lookahead slice on the byte selected by the beat counter.
    // Each carry is written out as a sum of generate/propagate products taken
    // from the slice carry-in, not chained from the carry below it.
    always_comb begin
        sl_a     = opa_q[{beat_q, 3'b000} +: 8];
        sl_b     = opb_q[{beat_q, 3'b000} +: 8];
        sl_g     = sl_a & sl_b;
        sl_p     = sl_a | sl_b;
        sl_c     = '0;
        la_term  = 1'b0;
        la_carry = 1'b0;
        sl_c[0]  = c_q;
        for (int i = 0; i < 8; i++) begin
            // Carry-in propagated through all of bits 0..i
            la_carry = c_q;
            for (int k = 0; k <= i; k++) begin
                la_carry = la_carry & sl_p[k];
            end
            // Generate at bit j, propagated through bits j+1..i
            for (int j = 0; j <= i; j++) begin
                la_term = sl_g[j];
                for (int k = j + 1; k <= i; k++) begin
                    la_term = la_term & sl_p[k];
                end
                la_carry = la_carry | la_term;
            end
            sl_c[i+1] = la_carry;
        end
        sl_sum = sl_a ^ sl_b ^ sl_c[7:0];
    end

    // Next-state and datapath updates for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        c_d      = c_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        rdy_d    = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    opa_d   = bus.data_operandA;
                    opb_d   = bus.ctrl_sub ? ~bus.data_operandB : bus.data_operandB;
                    c_d     = bus.ctrl_sub;
                    acc_d   = '0;
                    beat_d  = 2'd0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                acc_d[{beat_q, 3'b000} +: 8] = sl_sum;
                c_d    = sl_c[8];
                beat_d = beat_q + 2'd1;
                if (beat_q == 2'd3) begin
                    // The top byte comes straight from the slice, so the
                    // visible result is never a partly filled accumulator.
                    result_d = {sl_sum, acc_q[23:0]};
                    cout_d   = sl_c[8];
                    ovf_d    = sl_c[7] ^ sl_c[8];
                    rdy_d    = 1'b1;
                    state_d  = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset also cancels any operation in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            beat_q   <= 2'd0;
            c_q      <= 1'b0;
            opa_q    <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            c_q      <= c_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            rdy_q    <= rdy_d;
        end
    end

    assign bus.data_result    = result_q;
    assign bus.carry_out      = cout_q;
    assign bus.overflow       = ovf_q;
    assign bus.data_resultRDY = rdy_q;
    assign bus.busy           = (state_q == RUN);
    assign dbg_state_o        = state_q;

endmodule

// File: tb/tb_multicycle_adder_ctrl.sv
// Directed bench for multicycle_adder_ctrl. The driver pushes the hand-computed
// result and the expected ready cycle for each accepted request. The monitor
// pops an entry on every ready pulse and compares it with the outputs.
module tb_multicycle_adder_ctrl;

  logic       clock;
  logic       reset;
  logic [1:0] dbg_state;

  multicycle_adder_ctrl_if bus ();

  multicycle_adder_ctrl dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [33:0] exp_q[$];  // {result, carry_out, overflow}
  int          cyc_q[$];  // negedge cycle at which the ready pulse is expected
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  logic [33:0] mon_e;
  int          mon_c;
  always @(negedge clock) begin
    if (!reset && bus.data_resultRDY === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: got pulse with result 0x%0h expected no pulse (cycle %0d)",
                 bus.data_result, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        mon_c = cyc_q.pop_front();
        chk("result",    {32'd0, bus.data_result}, {32'd0, mon_e[33:2]});
        chk("carry_out", {63'd0, bus.carry_out},   {63'd0, mon_e[1]});
        chk("overflow",  {63'd0, bus.overflow},    {63'd0, mon_e[0]});
        chk("latency",   64'(cyc),                 64'(mon_c));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; start is sampled on the following posedge.
  task automatic issue(input logic sub, input logic [31:0] a, input logic [31:0] b,
                       input bit push, input logic [33:0] exp);
    bus.start         = 1'b1;
    bus.ctrl_sub      = sub;
    bus.data_operandA = a;
    bus.data_operandB = b;
    if (push) begin
      exp_q.push_back(exp);
      cyc_q.push_back(cyc + 5);
    end
    @(negedge clock);
    bus.start         = 1'b0;
    bus.ctrl_sub      = 1'($urandom_range(0, 1));
    bus.data_operandA = $urandom;
    bus.data_operandB = $urandom;
  endtask

  // Returns at the negedge where the ready pulse is visible.
  task automatic wait_rdy(output int busy_cycles);
    int n;
    busy_cycles = 0;
    n = 0;
    while (bus.data_resultRDY !== 1'b1 && n < 20) begin
      if (bus.busy === 1'b1) busy_cycles++;
      n++;
      @(negedge clock);
    end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL ready_timeout: got no ready within %0d cycles expected ready", n);
    end
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_result"}, {32'd0, bus.data_result},   64'd0);
    chk({tag, "_cout"},   {63'd0, bus.carry_out},     64'd0);
    chk({tag, "_ovf"},    {63'd0, bus.overflow},      64'd0);
    chk({tag, "_rdy"},    {63'd0, bus.data_resultRDY}, 64'd0);
    chk({tag, "_busy"},   {63'd0, bus.busy},          64'd0);
    chk({tag, "_state"},  {62'd0, dbg_state},         64'd0);
  endtask

  // ---------------- directed vectors ----------------
  logic        v_sub[4];
  logic [31:0] v_a[4];
  logic [31:0] v_b[4];
  logic [33:0] v_exp[4];

  initial begin
    int bc;

    v_sub[0] = 1'b0; v_a[0] = 32'h7FFF_FFFF; v_b[0] = 32'h0000_0001; v_exp[0] = {32'h8000_0000, 1'b0, 1'b1};
    v_sub[1] = 1'b0; v_a[1] = 32'hFFFF_FFFF; v_b[1] = 32'h0000_0001; v_exp[1] = {32'h0000_0000, 1'b1, 1'b0};
    v_sub[2] = 1'b1; v_a[2] = 32'h0000_0005; v_b[2] = 32'h0000_0007; v_exp[2] = {32'hFFFF_FFFE, 1'b0, 1'b0};
    v_sub[3] = 1'b1; v_a[3] = 32'h8000_0000; v_b[3] = 32'h0000_0001; v_exp[3] = {32'h7FFF_FFFF, 1'b1, 1'b1};

    reset             = 1'b1;
    bus.start         = 1'b0;
    bus.ctrl_sub      = 1'b0;
    bus.data_operandA = '0;
    bus.data_operandB = '0;
    repeat (3) @(negedge clock);
    chk_cleared("reset");
    reset = 1'b0;

    // 0xFF + 1: byte carry into byte 1; busy for exactly four cycles
    @(negedge clock);
    issue(1'b0, 32'h0000_00FF, 32'h0000_0001, 1'b1, {32'h0000_0100, 1'b0, 1'b0});
    wait_rdy(bc);
    chk("busy_cycles", 64'(bc), 64'd4);

    // Overflow, full carry ripple, and subtraction corners
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      issue(v_sub[i], v_a[i], v_b[i], 1'b1, v_exp[i]);
      wait_rdy(bc);
    end

    // Start during beat 1 is ignored; start in DONE is taken back-to-back
    @(negedge clock);
    issue(1'b0, 32'h1111_1111, 32'h2222_2222, 1'b1, {32'h3333_3333, 1'b0, 1'b0});
    @(negedge clock);
    issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, '0);
    wait_rdy(bc);
    issue(1'b1, 32'h0000_0010, 32'h0000_0001, 1'b1, {32'h0000_000F, 1'b1, 1'b0});
    wait_rdy(bc);

    // Reset on the beat-2 edge aborts with no ready pulse
    @(negedge clock);
    issue(1'b0, 32'hAAAA_AAAA, 32'h5555_5555, 1'b0, '0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk_cleared("abort");
    reset = 1'b0;
    @(negedge clock);
    issue(1'b0, 32'h0000_0001, 32'h0000_0001, 1'b1, {32'h0000_0002, 1'b0, 1'b0});
    wait_rdy(bc);

    // Reset wins over start on the same edge
    @(negedge clock);
    reset             = 1'b1;
    bus.start         = 1'b1;
    bus.ctrl_sub      = 1'b0;
    bus.data_operandA = 32'h0000_0003;
    bus.data_operandB = 32'h0000_0004;
    @(negedge clock);
    chk_cleared("rst_start");
    reset     = 1'b0;
    bus.start = 1'b0;
    repeat (8) @(negedge clock);
    chk("idle_state_after", {62'd0, dbg_state}, 64'd0);
    chk("idle_busy_after",  {63'd0, bus.busy},  64'd0);

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
